dht11_frame_receiver: RTL

- Downstream stage of the DHT11 start-signal generator.
- After the start stage releases the bus and pulses its confirm output, this block:
  - samples the single-wire data line;
  - checks the sensor response preamble;
  - decodes the 40-bit frame;
  - verifies the checksum.
- Presents humidity and temperature bytes with a one-cycle valid strobe, or an error strobe, to the consuming logic.

---
 rtl/dht11_pkg.sv | 34 +++
 rtl/dht11_frame_receiver_if.sv | 25 ++
 rtl/dht11_line_sync.sv | 43 ++++
 rtl/dht11_frame_receiver.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dht11_pkg.sv
// rtl/dht11_pkg.sv - shared state encoding, frame constants and helpers for the DHT11 receiver
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RESP,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_CHECK
  } state_e;

  localparam int FRAME_BITS    = 40;
  localparam int BIT_IDX_W     = 6;
  localparam int BYTE_HUM_INT  = 0;
  localparam int BYTE_HUM_DEC  = 1;
  localparam int BYTE_TEMP_INT = 2;
  localparam int BYTE_TEMP_DEC = 3;
  localparam int BYTE_CHKSUM   = 4;

  // Byte 0 is the first byte on the wire, i.e. the most significant byte of the shift register.
  function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] f, input int idx);
    return f[FRAME_BITS-1-8*idx -: 8];
  endfunction

  function automatic logic [7:0] checksum8(input logic [FRAME_BITS-1:0] f);
    logic [7:0] s;
    s = frame_byte(f, BYTE_HUM_INT) + frame_byte(f, BYTE_HUM_DEC)
      + frame_byte(f, BYTE_TEMP_INT) + frame_byte(f, BYTE_TEMP_DEC);
    return s;
  endfunction

endpackage

// File: rtl/dht11_frame_receiver_if.sv
// rtl/dht11_frame_receiver_if.sv - start/line inputs and decoded frame outputs of the DHT11 receiver
interface dht11_frame_receiver_if;

  logic       start;
  logic       dht_in;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic       valid;
  logic       chk_err;
  logic       tmo_err;
  logic       busy;

  modport master (
    output start, dht_in,
    input  hum_int, hum_dec, temp_int, temp_dec, valid, chk_err, tmo_err, busy
  );

  modport slave (
    input  start, dht_in,
    output hum_int, hum_dec, temp_int, temp_dec, valid, chk_err, tmo_err, busy
  );

endinterface

// File: rtl/dht11_line_sync.sv
// rtl/dht11_line_sync.sv - two-flop synchronizer with registered rise/fall pulses for a single-wire line
module dht11_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_s,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Edges are registered together with sync2 so a pulse lines up with the new level.
  always_comb begin
    sync1_d = line_in;
    sync2_d = sync1_q;
    rise_d  = sync1_q & ~sync2_q;
    fall_d  = ~sync1_q & sync2_q;
  end

  // The bus idles high through its pull-up, so resetting high avoids a spurious fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign line_s = sync2_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/dht11_frame_receiver.sv
// rtl/dht11_frame_receiver.sv - checks the DHT11 response preamble, decodes the 40-bit frame and verifies its checksum
module dht11_frame_receiver
  import dht11_pkg::*;
#(
  parameter int RESP_MIN_CYC    = 6,
  parameter int BIT1_THRESH_CYC = 5,
  parameter int TIMEOUT_CYC     = 20,
  parameter int CNT_W           = 8
) (
  input logic                    clk,
  input logic                    rst,
  dht11_frame_receiver_if.slave  bus
);

  localparam logic [CNT_W-1:0] RESP_MIN = CNT_W'(RESP_MIN_CYC);
  localparam logic [CNT_W-1:0] BIT1_THR = CNT_W'(BIT1_THRESH_CYC);
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT_CYC);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(FRAME_BITS - 1);

  logic line_s, line_rise, line_fall;

  dht11_line_sync u_line_sync (
    .clk     (clk),
    .rst     (rst),
    .line_in (bus.dht_in),
    .line_s  (line_s),
    .rise    (line_rise),
    .fall    (line_fall)
  );

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [7:0]             hum_int_q, hum_int_d;
  logic [7:0]             hum_dec_q, hum_dec_d;
  logic [7:0]             temp_int_q, temp_int_d;
  logic [7:0]             temp_dec_q, temp_dec_d;
  logic                   valid_q, valid_d;
  logic                   chk_err_q, chk_err_d;
  logic                   tmo_err_q, tmo_err_d;
  logic                   busy_q, busy_d;
  logic                   timed_out;

  always_comb begin
    cnt_inc    = (cnt_q >= TMO) ? TMO : cnt_q + 1'b1;
    timed_out  = (cnt_q >= TMO);
    state_d    = state_q;
    cnt_d      = cnt_inc;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    hum_int_d  = hum_int_q;
    hum_dec_d  = hum_dec_q;
    temp_int_d = temp_int_q;
    temp_dec_d = temp_dec_q;
    valid_d    = 1'b0;
    chk_err_d  = 1'b0;
    tmo_err_d  = 1'b0;
    // busy covers the strobe cycle and drops the cycle after it
    busy_d     = busy_q & ~(valid_q | chk_err_q | tmo_err_q);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.start && !busy_q) begin
          state_d   = ST_WAIT_RESP;
          busy_d    = 1'b1;
          bit_idx_d = '0;
          shift_d   = '0;
        end
      end
      ST_WAIT_RESP: begin
        if (line_fall) begin
          state_d = ST_RESP_LOW;
          cnt_d   = '0;
        end
      end
      ST_RESP_LOW: begin
        if (line_s) cnt_d = cnt_q;
        if (line_rise) begin
          cnt_d = '0;
          if (cnt_q >= RESP_MIN) begin
            state_d = ST_RESP_HIGH;
          end else begin
            state_d   = ST_IDLE;
            tmo_err_d = 1'b1;
          end
        end
      end
      ST_RESP_HIGH: begin
        if (!line_s) cnt_d = cnt_q;
        if (line_fall) begin
          cnt_d = '0;
          if (cnt_q >= RESP_MIN) begin
            state_d = ST_BIT_LOW;
          end else begin
            state_d   = ST_IDLE;
            tmo_err_d = 1'b1;
          end
        end
      end
      ST_BIT_LOW: begin
        if (line_rise) begin
          state_d = ST_BIT_HIGH;
          cnt_d   = '0;
        end
      end
      ST_BIT_HIGH: begin
        if (!line_s) cnt_d = cnt_q;
        if (line_fall) begin
          cnt_d   = '0;
          shift_d = {shift_q[FRAME_BITS-2:0], (cnt_q >= BIT1_THR)};
          if (bit_idx_q == LAST_BIT) begin
            state_d = ST_CHECK;
          end else begin
            state_d   = ST_BIT_LOW;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_CHECK: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
        if (checksum8(shift_q) == frame_byte(shift_q, BYTE_CHKSUM)) begin
          hum_int_d  = frame_byte(shift_q, BYTE_HUM_INT);
          hum_dec_d  = frame_byte(shift_q, BYTE_HUM_DEC);
          temp_int_d = frame_byte(shift_q, BYTE_TEMP_INT);
          temp_dec_d = frame_byte(shift_q, BYTE_TEMP_DEC);
          valid_d    = 1'b1;
        end else begin
          chk_err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A phase that runs to the limit overrides whatever the line did this cycle.
    if (timed_out && state_q != ST_IDLE && state_q != ST_CHECK) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      tmo_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      hum_int_q  <= 8'h00;
      hum_dec_q  <= 8'h00;
      temp_int_q <= 8'h00;
      temp_dec_q <= 8'h00;
      valid_q    <= 1'b0;
      chk_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      hum_int_q  <= hum_int_d;
      hum_dec_q  <= hum_dec_d;
      temp_int_q <= temp_int_d;
      temp_dec_q <= temp_dec_d;
      valid_q    <= valid_d;
      chk_err_q  <= chk_err_d;
      tmo_err_q  <= tmo_err_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.hum_int  = hum_int_q;
  assign bus.hum_dec  = hum_dec_q;
  assign bus.temp_int = temp_int_q;
  assign bus.temp_dec = temp_dec_q;
  assign bus.valid    = valid_q;
  assign bus.chk_err  = chk_err_q;
  assign bus.tmo_err  = tmo_err_q;
  assign bus.busy     = busy_q;

endmodule
